// File: rtl/interrupt_controller.sv
// Interrupt entry / RTI return sequencer for the five-stage pipeline: drains the pipe,
// pushes PC and CCR through the memory stage, vectors fetch, and reverses it on RTI.
module interrupt_controller #(
  parameter int unsigned DRAIN_CYCLES = 3,
  parameter logic [31:0] VECTOR_ADDR  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        int_pin,
  input  logic        rti_exec,
  input  logic        branch_busy,
  output logic        int_signal,
  output logic        rti_pop,
  output logic [1:0]  counter_value,
  output logic        fetch_stall,
  output logic        flush,
  output logic        pc_load,
  output logic [31:0] pc_load_value,
  output logic        pc_restore,
  output logic        int_pending,
  output logic        in_service
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRAIN,
    S_SAVE,
    S_VECTOR,
    S_RESTORE,
    S_RESUME
  } state_t;

  localparam logic [3:0] DRAIN_LAST = 4'(DRAIN_CYCLES - 1);
  localparam logic [3:0] WORD_LAST  = 4'd2;

  state_t     state, state_d;
  logic [3:0] cnt, cnt_d;
  logic       int_pin_q;
  logic       rearm;      // edge seen after the current entry already committed
  logic       pin_edge;

  assign pin_edge      = int_pin & ~int_pin_q;
  assign pc_load_value = VECTOR_ADDR;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    state_d = state;
    cnt_d   = cnt;
    unique case (state)
      S_IDLE: begin
        cnt_d = '0;
        if (rti_exec && in_service) begin
          state_d = S_RESTORE;
        end else if (int_pending && !in_service && !branch_busy) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (cnt == DRAIN_LAST) begin
          state_d = S_SAVE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + 4'd1;
        end
      end
      S_SAVE: begin
        if (cnt == WORD_LAST) begin
          state_d = S_VECTOR;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + 4'd1;
        end
      end
      S_RESTORE: begin
        if (cnt == WORD_LAST) begin
          state_d = S_RESUME;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + 4'd1;
        end
      end
      S_VECTOR, S_RESUME: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Strobes are registered from the next state, so they are a pure Moore decode of state/cnt.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      state         <= S_IDLE;
      cnt           <= '0;
      int_pin_q     <= 1'b1;
      rearm         <= 1'b0;
      int_pending   <= 1'b0;
      in_service    <= 1'b0;
      int_signal    <= 1'b0;
      rti_pop       <= 1'b0;
      counter_value <= 2'd0;
      fetch_stall   <= 1'b0;
      flush         <= 1'b0;
      pc_load       <= 1'b0;
      pc_restore    <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      int_pin_q <= int_pin;

      unique case (state)
        S_VECTOR: begin
          in_service  <= 1'b1;
          int_pending <= rearm | pin_edge;
          rearm       <= 1'b0;
        end
        S_DRAIN, S_SAVE: begin
          if (pin_edge) rearm <= 1'b1;
        end
        default: begin
          if (pin_edge) int_pending <= 1'b1;
          if (state == S_RESUME) in_service <= 1'b0;
        end
      endcase

      int_signal  <= (state_d == S_SAVE);
      rti_pop     <= (state_d == S_RESTORE);
      fetch_stall <= (state_d inside {S_DRAIN, S_SAVE, S_RESTORE});
      flush       <= (state_d inside {S_DRAIN, S_SAVE, S_RESTORE});
      pc_load     <= (state_d == S_VECTOR);
      pc_restore  <= (state_d == S_RESUME);
      if (state_d == S_SAVE) begin
        counter_value <= cnt_d[1:0];
      end else if (state_d == S_RESTORE) begin
        counter_value <= 2'd2 - cnt_d[1:0];
      end else begin
        counter_value <= 2'd0;
      end
    end
  end

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed test-plan sequences followed by random traffic, all checked every cycle
// against an offset-based reference model of the entry and RTI sequences.
module tb_interrupt_controller;

  localparam int          D     = 3;
  localparam logic [31:0] VADDR = 32'h0000_8000;

  logic        clk = 1'b0;
  logic        reset, int_pin, rti_exec, branch_busy;
  logic        int_signal, rti_pop, fetch_stall, flush, pc_load, pc_restore;
  logic        int_pending, in_service;
  logic [1:0]  counter_value;
  logic [31:0] pc_load_value;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Reference model: which sequence is running (0 none, 1 entry, 2 rti) and how far into it.
  int   m_kind = 0;
  int   m_off  = 0;
  logic m_pend = 1'b0;
  logic m_svc  = 1'b0;
  logic m_queued = 1'b0;
  logic m_prev = 1'b1;

  interrupt_controller #(.DRAIN_CYCLES(D), .VECTOR_ADDR(VADDR)) dut (
    .clk(clk), .reset(reset), .int_pin(int_pin), .rti_exec(rti_exec),
    .branch_busy(branch_busy), .int_signal(int_signal), .rti_pop(rti_pop),
    .counter_value(counter_value), .fetch_stall(fetch_stall), .flush(flush),
    .pc_load(pc_load), .pc_load_value(pc_load_value), .pc_restore(pc_restore),
    .int_pending(int_pending), .in_service(in_service)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: observed no finish, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s @cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_update(input logic p, input logic r, input logic b, input logic rs);
    logic e;
    if (rs) begin
      m_kind = 0; m_off = 0; m_pend = 0; m_svc = 0; m_queued = 0; m_prev = 1;
      return;
    end
    e = p & ~m_prev;
    m_prev = p;
    case (m_kind)
      0: begin
        if (r && m_svc) begin
          m_kind = 2; m_off = 0;
        end else if (m_pend && !m_svc && !b) begin
          m_kind = 1; m_off = 0;
        end
        if (e) m_pend = 1;
      end
      1: begin
        if (m_off == D + 3) begin
          m_kind = 0; m_svc = 1; m_pend = m_queued | e; m_queued = 0;
        end else begin
          m_off++;
          if (e) m_queued = 1;
        end
      end
      default: begin
        if (m_off == 3) begin
          m_kind = 0; m_svc = 0;
        end else begin
          m_off++;
        end
        if (e) m_pend = 1;
      end
    endcase
  endtask

  task automatic compare_all();
    logic e_int, e_pop, e_stall, e_load, e_rest;
    logic [1:0] e_cv;
    e_int = 0; e_pop = 0; e_stall = 0; e_load = 0; e_rest = 0; e_cv = 0;
    if (m_kind == 1) begin
      if (m_off < D) e_stall = 1;
      else if (m_off < D + 3) begin e_int = 1; e_stall = 1; e_cv = 2'(m_off - D); end
      else e_load = 1;
    end else if (m_kind == 2) begin
      if (m_off < 3) begin e_pop = 1; e_stall = 1; e_cv = 2'(2 - m_off); end
      else e_rest = 1;
    end
    check("int_signal", int_signal, e_int);
    check("rti_pop", rti_pop, e_pop);
    check("counter_value", counter_value, e_cv);
    check("fetch_stall", fetch_stall, e_stall);
    check("flush", flush, e_stall);
    check("pc_load", pc_load, e_load);
    check("pc_restore", pc_restore, e_rest);
    check("int_pending", int_pending, m_pend);
    check("in_service", in_service, m_svc);
    check("pc_load_value", pc_load_value, VADDR);
  endtask

  // Inputs given here are held through the cycle and sampled at the next rising edge.
  task automatic step(input logic p, input logic r, input logic b, input logic rs);
    int_pin = p; rti_exec = r; branch_busy = b; reset = rs;
    @(posedge clk);
    model_update(p, r, b, rs);
    cyc++;
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    logic rp;
    int_pin = 0; rti_exec = 0; branch_busy = 0; reset = 1;

    // Reset, then pin rises during cycle 5.
    step(0, 0, 0, 1);
    check("pc_load_value_reset", pc_load_value, VADDR);
    repeat (4) step(0, 0, 0, 0);
    for (int c = 6; c <= 14; c++) begin
      step(1, 0, 0, 0);
      check("tp_stall", fetch_stall, (c >= 7 && c <= 12));
      check("tp_int_signal", int_signal, (c >= 10 && c <= 12));
      if (c >= 10 && c <= 12) check("tp_cv", counter_value, c - 10);
      check("tp_pc_load", pc_load, (c == 13));
    end
    check("tp_in_service", in_service, 1);
    check("tp_pending_clear", int_pending, 0);

    // RTI pulse: pop 2,1,0 then restore, then leave service.
    repeat (2) step(1, 0, 0, 0);
    for (int k = 1; k <= 5; k++) begin
      step(1, k == 1, 0, 0);
      check("rti_pop_t", rti_pop, (k <= 3));
      if (k <= 3) check("rti_cv_t", counter_value, 3 - k);
      check("pc_restore_t", pc_restore, (k == 4));
      check("in_service_t", in_service, (k < 5));
    end

    // Second edge during SAVE stays pending until the RTI completes.
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    repeat (3) step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    repeat (3) step(1, 0, 0, 0);
    check("rearm_pending", int_pending, 1);
    check("rearm_service", in_service, 1);
    repeat (5) begin
      step(1, 0, 0, 0);
      check("no_nesting", fetch_stall, 0);
    end
    step(1, 1, 0, 0);
    repeat (4) step(1, 0, 0, 0);
    check("after_resume_idle", fetch_stall, 0);
    step(1, 0, 0, 0);
    check("drain_after_resume", fetch_stall, 1);
    repeat (8) step(1, 0, 0, 0);

    // Leave service, then hold branch_busy while pending.
    step(1, 1, 0, 0);
    repeat (5) step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    step(1, 0, 1, 0);
    repeat (4) begin
      step(1, 0, 1, 0);
      check("branch_defer", fetch_stall, 0);
    end
    step(1, 0, 0, 0);
    check("branch_release", fetch_stall, 1);

    // Reset in the middle of SAVE with counter_value = 1, pin held high.
    repeat (4) step(1, 0, 0, 0);
    check("mid_save_cv", counter_value, 1);
    step(1, 0, 0, 1);
    check("rst_int_signal", int_signal, 0);
    check("rst_counter", counter_value, 0);
    check("rst_stall", fetch_stall, 0);
    repeat (6) begin
      step(1, 0, 0, 0);
      check("held_pin_no_entry", fetch_stall, 0);
    end

    // RTI outside service is ignored.
    step(1, 1, 0, 0);
    check("rti_ignored", rti_pop, 0);
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    repeat (9) step(1, 0, 0, 0);
    check("svc_before_combo", in_service, 1);
    // RTI together with a new edge: restore first, then entry.
    step(0, 0, 0, 0);
    step(1, 1, 0, 0);
    check("combo_pop_first", rti_pop, 1);
    check("combo_pending", int_pending, 1);
    repeat (4) step(1, 0, 0, 0);
    check("combo_idle", fetch_stall, 0);
    step(1, 0, 0, 0);
    check("combo_entry", fetch_stall, 1);
    repeat (10) step(1, 0, 0, 0);

    // Random traffic against the model.
    step(0, 0, 0, 1);
    rp = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(7) == 0) rp = ~rp;
      step(rp, $urandom_range(9) == 0, $urandom_range(3) == 0, $urandom_range(199) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/interrupt_controller.md
# interrupt_controller

Sequences interrupt entry and RTI return for the five-stage pipeline. It detects rising edges on the external interrupt pin and drains the pipeline. It then drives the memory stage's interrupt signal and 2-bit counter-value inputs so that PC and flags are pushed one word per cycle, and finally redirects fetch to the vector. It runs the reverse sequence, popping the saved words, when the decode stage reports an RTI.

## Interface
- `DRAIN_CYCLES`, 3: cycles of fetch stall + NOP injection before the first push (1..15).
- `VECTOR_ADDR`, 32'h0000_0000: address loaded into PC on interrupt entry.
- `clk`  in  1  system clock, all state changes on rising edge.
- `reset`  in  1  synchronous, active-high; one clock; reset is synchronous and active-high.
- `int_pin`  in  1  external interrupt request; rising edge is the event.
- `rti_exec`  in  1  one-cycle pulse from decode when an RTI opcode is decoded.
- `branch_busy`  in  1  a taken branch/jump is in execute; entry is deferred while high.
- `int_signal`  out  1  to memory stage: push the word selected by `counter_value`.
- `rti_pop`  out  1  to memory stage: pop into the slot selected by `counter_value`.
- `counter_value`  out  2  slot select: 0 = PC[15:0], 1 = PC[31:16], 2 = CCR, 3 unused.
- `fetch_stall`  out  1  freezes PC and the fetch/decode register.
- `flush`  out  1  forces the NOP opcode through `cu_mux`.
- `pc_load`  out  1  fetch loads `pc_load_value` this cycle.
- `pc_load_value`  out  32  constant `VECTOR_ADDR`.
- `pc_restore`  out  1  fetch commits the popped PC this cycle.
- `int_pending`  out  1  an edge is latched and not yet serviced.
- `in_service`  out  1  a handler is running (between VECTOR and RESUME).

## Operation
- Edge detect: `int_pin_q` is registered every cycle. An edge is `int_pin & ~int_pin_q`. The edge sets `int_pending`. Further edges while pending are absorbed, with no count.
- States: IDLE, DRAIN, SAVE, VECTOR, RESTORE, RESUME. 4-bit `cnt`.
- IDLE -> RESTORE when `rti_exec & in_service`. RTI takes priority over a pending entry in the same cycle. `rti_exec` with `in_service`=0 is ignored.
- IDLE -> DRAIN when `int_pending & ~in_service & ~branch_busy`. No nesting: a pending edge waits until the handler's RTI completes.
- DRAIN: `fetch_stall`=`flush`=1 for exactly `DRAIN_CYCLES` cycles, then SAVE.
- SAVE: 3 cycles with `int_signal`=1, `fetch_stall`=`flush`=1, and `counter_value` = 0, 1, 2 in order. Then VECTOR.
- VECTOR: 1 cycle with `pc_load`=1 and `fetch_stall`=0. On exit, `in_service` is set, `int_pending` is cleared, and the FSM goes to IDLE.
- RESTORE: 3 cycles with `rti_pop`=1, `fetch_stall`=`flush`=1, and `counter_value` = 2, 1, 0 (LIFO against SAVE). Then RESUME.
- RESUME: 1 cycle with `pc_restore`=1. On exit, `in_service` is cleared and the FSM goes to IDLE.
- All outputs are Moore, decoded from registered state/`cnt`. Outside SAVE/RESTORE, `counter_value`=0.
- An edge arriving in any non-IDLE state is latched and serviced later. Its edge is never lost.
- `branch_busy` is sampled only in IDLE. It has no effect once DRAIN has started.

## Timing
- Reset (any state, including mid-SAVE/RESTORE) gives: state IDLE, `cnt`=0, `int_pending`=0, `in_service`=0, all strobes 0, `counter_value`=0.
- Reset also sets `int_pin_q`=1, so a pin held high through reset does not interrupt. The pin must go low, then high.
- Edge sampled at edge E gives `int_pending`=1 after E. DRAIN is entered at E+1 if the entry conditions hold, so `fetch_stall` rises 2 cycles after the pin rises.
- Entry length from first DRAIN cycle to return to IDLE is `DRAIN_CYCLES`+4 cycles. RTI length is 4 cycles.
- `pc_load_value` equals `VECTOR_ADDR` at all times, including during reset.

## Test plan
- Reset, `int_pin` 0->1 at cycle 5:
  - `fetch_stall` is high cycles 7-12.
  - `int_signal` is high cycles 10-12 with `counter_value` 0, 1, 2.
  - `pc_load` is high at cycle 13.
  - `in_service`=1 and `int_pending`=0 from cycle 14.
- Handler running, `rti_exec` pulse at cycle T:
  - `rti_pop` is high T+1..T+3 with `counter_value` 2, 1, 0.
  - `pc_restore` is high at T+4.
  - `in_service`=0 at T+5.
- Second `int_pin` edge during SAVE:
  - `int_pending` stays 1 after VECTOR.
  - No DRAIN occurs until the RTI completes; DRAIN then starts 1 cycle after RESUME exits.
- `branch_busy`=1 for 4 cycles while pending: DRAIN starts the cycle after `branch_busy` drops.
- Reset asserted during SAVE (`counter_value`=1): the next cycle has all outputs 0 and state IDLE. With `int_pin` still high, there is no new entry.
- `rti_exec` with `in_service`=0, and `rti_exec` coinciding with a new edge:
  - The first is ignored.
  - The second runs RESTORE first, then the entry sequence.
